fusion_stim_gen: RTL and testbench

Upstream stimulus stage for the fusiont checker. It takes a command descriptor over a valid/ready handshake and produces the cycle-exact start/a/b/c waveforms that fusiont consumes. It runs one sequence at a time, signals completion with a done pulse, and counts completed sequences. All outputs are registered, so they are stable for fusiont, which samples on the opposite clock edge.

---
 rtl/fusion_pkg.sv | 28 ++
 rtl/fusion_dly_cnt.sv | 36 +++
 rtl/fusion_stim_gen.sv | 151 +++++++++++++++
 tb/tb_fusion_stim_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fusion_pkg.sv
// Shared types for the fusiont stimulus generator.
// State encoding, command bundle and default widths.
package fusion_pkg;

  localparam int FUS_DLY_W = 4;
  localparam int FUS_LEN_W = 4;
  localparam int FUS_CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    ACTIVE,
    DONE
  } fusion_state_e;

  typedef struct packed {
    logic [FUS_DLY_W-1:0] dly;
    logic [FUS_LEN_W-1:0] len;
    logic                 b_en;
    logic                 c_en;
  } fusion_cmd_t;

  function automatic int max_w(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/fusion_dly_cnt.sv
// Loadable down-counter shared by the WAIT and ACTIVE phases.
// zero_n flags that the value after this edge will be zero.
module fusion_dly_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] ld_val,
  output logic         zero,
  output logic         zero_n
);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_n;

  always_comb begin
    cnt_n = cnt;
    if (load)
      cnt_n = ld_val;
    else if (dec)
      cnt_n = cnt - W'(1);
  end

  assign zero   = (cnt == '0);
  assign zero_n = (cnt_n == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else
      cnt <= cnt_n;
  end

endmodule

// File: rtl/fusion_stim_gen.sv
// Stimulus stage for fusiont: turns one command into
// registered start/a/b/c waveforms plus done/seq_cnt.
module fusion_stim_gen
  import fusion_pkg::*;
#(
  parameter int DLY_W = FUS_DLY_W,
  parameter int LEN_W = FUS_LEN_W,
  parameter int CNT_W = FUS_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [DLY_W-1:0] cmd_dly,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_b_en,
  input  logic             cmd_c_en,
  input  logic             abort,
  output logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] seq_cnt
);

  localparam int CW = max_w(DLY_W, LEN_W);

  fusion_state_e state, state_n;
  fusion_cmd_t   cmd_q;

  logic          take;
  logic          inc;
  logic          ld;
  logic          dec;
  logic [CW-1:0] ld_val;
  logic          zero;
  logic          zero_n;

  logic start_n, a_n, b_n, c_n;
  logic done_n, busy_n, rdy_n;

  fusion_dly_cnt #(.W(CW)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (ld),
    .dec    (dec),
    .ld_val (ld_val),
    .zero   (zero),
    .zero_n (zero_n)
  );

  always_comb begin
    state_n = state;
    take    = 1'b0;
    inc     = 1'b0;
    ld      = 1'b0;
    dec     = 1'b0;
    ld_val  = '0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          take    = 1'b1;
          state_n = START;
        end
      end
      START: begin
        if (abort) begin
          state_n = IDLE;
        end else if (cmd_q.dly == '0) begin
          state_n = ACTIVE;
          ld      = 1'b1;
          ld_val  = CW'(cmd_q.len);
        end else begin
          state_n = WAIT;
          ld      = 1'b1;
          ld_val  = CW'(cmd_q.dly) - CW'(1);
        end
      end
      WAIT: begin
        if (abort) begin
          state_n = IDLE;
        end else if (zero) begin
          state_n = ACTIVE;
          ld      = 1'b1;
          ld_val  = CW'(cmd_q.len);
        end else begin
          dec = 1'b1;
        end
      end
      ACTIVE: begin
        if (abort)
          state_n = IDLE;
        else if (zero)
          state_n = DONE;
        else
          dec = 1'b1;
      end
      DONE: begin
        state_n = IDLE;
        inc     = !abort;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are precomputed from the next state so they leave flops.
  always_comb begin
    start_n = (state_n == START);
    a_n     = (state_n == ACTIVE);
    b_n     = a_n && cmd_q.b_en;
    c_n     = a_n && cmd_q.c_en && zero_n;
    done_n  = (state_n == DONE);
    busy_n  = (state_n != IDLE);
    rdy_n   = (state_n == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_q     <= '0;
      seq_cnt   <= '0;
      start     <= 1'b0;
      a         <= 1'b0;
      b         <= 1'b0;
      c         <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state     <= state_n;
      start     <= start_n;
      a         <= a_n;
      b         <= b_n;
      c         <= c_n;
      done      <= done_n;
      busy      <= busy_n;
      cmd_ready <= rdy_n;
      if (take) begin
        cmd_q.dly  <= cmd_dly;
        cmd_q.len  <= cmd_len;
        cmd_q.b_en <= cmd_b_en;
        cmd_q.c_en <= cmd_c_en;
      end
      if (inc)
        seq_cnt <= seq_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fusion_stim_gen.sv
// Directed bench for fusion_stim_gen.
// Inputs change and outputs are sampled on the falling edge.
module tb_fusion_stim_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_dly;
  logic [3:0] cmd_len;
  logic       cmd_b_en;
  logic       cmd_c_en;
  logic       abort;
  logic       start, a, b, c, busy, done;
  logic [7:0] seq_cnt;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_cnt = 8'd0;

  always #5 clk = ~clk;

  fusion_stim_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dly   (cmd_dly),
    .cmd_len   (cmd_len),
    .cmd_b_en  (cmd_b_en),
    .cmd_c_en  (cmd_c_en),
    .abort     (abort),
    .start     (start),
    .a         (a),
    .b         (b),
    .c         (c),
    .busy      (busy),
    .done      (done),
    .seq_cnt   (seq_cnt)
  );

  typedef struct {
    logic [3:0] dly;
    logic [3:0] len;
    logic       b_en;
    logic       c_en;
    int         first_a;
    int         a_cycles;
    int         last_a;
    int         done_at;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_cmd(input logic [3:0] d, input logic [3:0] l,
                           input logic be, input logic ce);
    cmd_valid = 1'b1;
    cmd_dly   = d;
    cmd_len   = l;
    cmd_b_en  = be;
    cmd_c_en  = ce;
  endtask

  // Entered just after a falling edge with the block in IDLE.
  task automatic run_vec(input vec_t v, input int idx);
    logic ea;
    logic [4:0] ev;
    chk($sformatf("v%0d_ready", idx), cmd_ready, 1);
    drive_cmd(v.dly, v.len, v.b_en, v.c_en);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk($sformatf("v%0d_start", idx),
        {start, a, b, c, done, busy, cmd_ready}, 7'b1000010);
    for (int k = 2; k <= v.done_at; k++) begin
      @(negedge clk);
      ea = (k >= v.first_a) && (k < v.first_a + v.a_cycles);
      ev = {1'b0, ea, ea & v.b_en, v.c_en && (k == v.last_a),
            k == v.done_at};
      chk($sformatf("v%0d_cyc%0d", idx, k), {start, a, b, c, done}, ev);
    end
    exp_cnt++;
    @(negedge clk);
    chk($sformatf("v%0d_end", idx), {cmd_ready, busy, done}, 3'b100);
    chk($sformatf("v%0d_cnt", idx), seq_cnt, exp_cnt);
  endtask

  initial begin
    int starts;
    int last;
    int cyc;
    logic [7:0] base;
    logic seen;

    vecs[0] = '{4'd0,  4'd0,  1'b1, 1'b1, 2,  1,  2,  3};
    vecs[1] = '{4'd3,  4'd2,  1'b0, 1'b1, 5,  3,  7,  8};
    vecs[2] = '{4'd15, 4'd15, 1'b1, 1'b0, 17, 16, 32, 33};
    vecs[3] = '{4'd1,  4'd4,  1'b1, 1'b1, 3,  5,  7,  8};
    vecs[4] = '{4'd7,  4'd0,  1'b0, 1'b0, 9,  1,  9,  10};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_dly   = '0;
    cmd_len   = '0;
    cmd_b_en  = 1'b0;
    cmd_c_en  = 1'b0;
    abort     = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_outs", {start, a, b, c, busy, done}, 6'b0);
    chk("rst_cnt", seq_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Asynchronous reset in the middle of the a window.
    drive_cmd(4'd0, 4'd5, 1'b1, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_a_high", {a, b, busy}, 3'b111);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {start, a, b, c, busy, done}, 6'b0);
    chk("async_rst_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_cnt", seq_cnt, 0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Abort while waiting: no a, no done, no count.
    drive_cmd(4'd5, 4'd1, 1'b1, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("abw_wait", {start, a, busy}, 3'b001);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abw_outs", {start, a, b, c, done, busy}, 6'b0);
    chk("abw_ready", cmd_ready, 1);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | a | done;
    end
    chk("abw_quiet", seen, 0);
    chk("abw_cnt", seq_cnt, exp_cnt);

    // Abort in IDLE alongside a command: the command still runs.
    abort = 1'b1;
    drive_cmd(4'd0, 4'd0, 1'b0, 1'b1);
    @(negedge clk);
    abort     = 1'b0;
    cmd_valid = 1'b0;
    chk("abi_start", {start, busy}, 2'b11);
    @(negedge clk);
    chk("abi_abc", {a, b, c}, 3'b101);
    @(negedge clk);
    chk("abi_done", done, 1);
    exp_cnt++;
    @(negedge clk);
    chk("abi_cnt", seq_cnt, exp_cnt);

    // Abort during DONE suppresses the increment.
    drive_cmd(4'd0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("abd_done", done, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abd_cnt", seq_cnt, exp_cnt);
    chk("abd_ready", {cmd_ready, busy, done}, 3'b100);

    // 256 back-to-back commands with cmd_valid held high.
    base   = exp_cnt;
    starts = 0;
    last   = -1;
    cyc    = 0;
    drive_cmd(4'd0, 4'd0, 1'b1, 1'b0);
    while (starts < 256 && cyc < 1200) begin
      @(negedge clk);
      cyc++;
      if (start) begin
        starts++;
        if (last >= 0) chk("b2b_gap", cyc - last, 4);
        last = cyc;
        chk("b2b_cnt", seq_cnt, 8'(base + 8'(starts - 1)));
        if (starts == 256) cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    if (starts < 256) chk("b2b_timeout", starts, 256);
    repeat (3) @(negedge clk);
    chk("b2b_wrap_cnt", seq_cnt, exp_cnt);
    chk("b2b_ready", {cmd_ready, busy}, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
